conv_pass_sched: RTL and testbench



---
 rtl/conv_pass_sched_pkg.sv | 24 ++
 rtl/conv_pass_sched_addr.sv | 32 +++
 rtl/conv_pass_sched.sv | 142 ++++++++++++++
 tb/tb_conv_pass_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pass_sched_pkg.sv
// Shared definitions for the convolution pass scheduler.
//   pass_state_t  : scheduler FSM states (3-bit encoding)
//   fmap_addr_w() : feature-map address width for an S x S map
//   pair_idx_w()  : filter-pair index width for NF filters (min 1)
// The convolution top also uses pair_idx_w() to size the weight-buffer index.
package conv_pass_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FIN    = 3'd4
    } pass_state_t;

    function automatic int fmap_addr_w(input int s);
        return (s * s > 1) ? $clog2(s * s) : 1;
    endfunction

    function automatic int pair_idx_w(input int nf);
        return (nf / 2 > 1) ? $clog2(nf / 2) : 1;
    endfunction

endpackage

// File: rtl/conv_pass_sched_addr.sv
// raster_addr_gen: stall-aware raster address counter over an S x S map.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance one address (a read is issued this cycle)
//   addr     : current read address, 0 .. S*S-1
//   last     : addr is the final pixel of the map
// Advancing from the final address wraps to 0, so the counter is already
// parked at the start of the map for the next pass.
module raster_addr_gen
    import conv_pass_sched_pkg::*;
#(
    parameter int S      = 482,
    parameter int ADDR_W = fmap_addr_w(S)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(S * S - 1);

    assign last = (addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (en)
            addr <= last ? '0 : addr + 1'b1;
    end

endmodule

// File: rtl/conv_pass_sched.sv
// conv_pass_sched: sequences one convolution layer. Streams the S x S feature
// map from single-port memory into the window buffer once per filter pair,
// advances the weight buffer between passes and pulses done after NF/2 passes.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a layer (only looked at in IDLE)
//   stall           : downstream hold, freezes streaming this cycle
//   busy, done, err : layer in progress / end-of-layer pulse / sticky protocol error
//   mem_rd_en, mem_addr, mem_rd_data : feature-map memory read port (1-cycle latency)
//   din, valid_in, repeat_in         : pixel stream to the window buffer
//   fmap_finish     : window buffer end-of-map pulse
//   filter_adv, filter_sel           : weight-buffer advance pulse / current pair
module conv_pass_sched
    import conv_pass_sched_pkg::*;
#(
    parameter int M      = 8,
    parameter int S      = 482,
    parameter int NF     = 16,
    parameter int ADDR_W = fmap_addr_w(S),
    parameter int FC_W   = pair_idx_w(NF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [M-1:0]      mem_rd_data,
    output logic [M-1:0]      din,
    output logic              valid_in,
    output logic              repeat_in,
    input  logic              fmap_finish,
    output logic              filter_adv,
    output logic [FC_W-1:0]   filter_sel
);

    localparam logic [FC_W-1:0] LAST_PAIR = FC_W'(NF / 2 - 1);

    pass_state_t state;
    logic        addr_last;
    logic        final_rd;
    logic        fin_seen;   // fmap_finish arrived at/after the final read

    // Read strobe follows stall directly so a stalled cycle issues no read.
    assign mem_rd_en = (state == ST_STREAM) && !stall;
    assign final_rd  = mem_rd_en && addr_last;

    raster_addr_gen #(
        .S      (S),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk  (clk),
        .rst  (rst),
        .en   (mem_rd_en),
        .addr (mem_addr),
        .last (addr_last)
    );

    // The memory's own read register is the pipeline stage: its data lands in
    // the cycle after the strobe, which is exactly when the delayed strobe
    // (valid_in) is high. din is held at zero whenever it is not qualified.
    always_ff @(posedge clk) begin
        if (rst)
            valid_in <= 1'b0;
        else
            valid_in <= mem_rd_en;
    end

    assign din = valid_in ? mem_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            repeat_in  <= 1'b0;
            filter_adv <= 1'b0;
            filter_sel <= '0;
            fin_seen   <= 1'b0;
        end else begin
            done       <= 1'b0;
            filter_adv <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        filter_sel <= '0;
                        fin_seen   <= 1'b0;
                        repeat_in  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // End-of-map before the last pixel was even read is a
                    // protocol error; the pass still runs to completion.
                    if (fmap_finish) begin
                        if (final_rd)
                            fin_seen <= 1'b1;
                        else
                            err <= 1'b1;
                    end
                    if (final_rd)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fin_seen || fmap_finish) begin
                        fin_seen  <= 1'b0;
                        repeat_in <= 1'b0;
                        state     <= ST_NEXT;
                        // Issued here so the pulse sits in NEXT, one cycle
                        // ahead of the next pass's first read.
                        if (filter_sel != LAST_PAIR)
                            filter_adv <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (filter_sel == LAST_PAIR) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        filter_sel <= filter_sel + 1'b1;
                        repeat_in  <= 1'b1;
                        state      <= ST_STREAM;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pass_sched.sv
// Self-checking bench for conv_pass_sched with S=5, NF=4. A monitor on the
// falling edge scoreboards every read (expected pixel pushed from the bench's
// own address order) against every valid_in beat, and models the window
// buffer's fmap_finish pulse ff_delay cycles after the final read.
module tb_conv_pass_sched;

    localparam int M  = 8;
    localparam int S  = 5;
    localparam int NF = 4;
    localparam int N  = S * S;
    localparam int AW = $clog2(N);
    localparam int FW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          busy, done, err, mem_rd_en, valid_in, repeat_in, filter_adv;
    logic [AW-1:0] mem_addr;
    logic [M-1:0]  mem_rd_data = '0;
    logic [M-1:0]  din;
    logic [FW-1:0] filter_sel;
    logic          fmap_finish;
    logic          ff_model = 1'b0;
    logic          ff_force = 1'b0;

    assign fmap_finish = ff_model | ff_force;

    always #5 clk = ~clk;

    conv_pass_sched #(.M(M), .S(S), .NF(NF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .din         (din),
        .valid_in    (valid_in),
        .repeat_in   (repeat_in),
        .fmap_finish (fmap_finish),
        .filter_adv  (filter_adv),
        .filter_sel  (filter_sel)
    );

    int         chk_cnt = 0, pass_cnt = 0, cyc = 0;
    logic [M-1:0] mem [N];
    logic [M-1:0] sb_q [$];
    logic [M-1:0] mon_exp;
    int         exp_addr = 0, ff_delay = 3, ff_cnt = 0;
    bit         ff_arm = 0, stall_en = 0;
    int         valid_cnt = 0, done_cnt = 0, adv_cnt = 0;

    // Single-port memory, one-cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    always @(posedge clk) begin
        #1;
        stall = stall_en && ($urandom_range(99) < 30);
    end

    always @(negedge clk) begin
        ff_model = 1'b0;
        if (rst) begin
            sb_q.delete();
            exp_addr = 0;
            ff_cnt   = 0;
            ff_arm   = 0;
        end else begin
            if (ff_arm) begin
                ff_cnt--;
                if (ff_cnt == 0) begin ff_model = 1'b1; ff_arm = 0; end
            end
            if (valid_in) begin
                valid_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0)
                    $display("FAIL sb_valid: valid_in=1 with no read outstanding");
                else begin
                    mon_exp = sb_q.pop_front();
                    if (din !== mon_exp) $display("FAIL sb_din: got %h want %h", din, mon_exp);
                    else pass_cnt++;
                end
            end
            if (mem_rd_en) begin
                chk_cnt++;
                if (mem_addr !== AW'(exp_addr)) $display("FAIL sb_addr: got %0d want %0d", mem_addr, exp_addr);
                else pass_cnt++;
                sb_q.push_back(mem[exp_addr]);
                if (exp_addr == N - 1) begin
                    if (ff_delay == 0) ff_model = 1'b1;
                    else begin ff_cnt = ff_delay; ff_arm = 1; end
                end
                exp_addr = (exp_addr + 1) % N;
            end
            if (done) done_cnt++;
            if (filter_adv) adv_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
        cyc++;
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) mem[i] = M'($urandom);
    endtask

    // Raises start in the current cycle t; returns in cycle t+1.
    task automatic start_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        chk_cnt++;
        if ({busy, done, err, mem_rd_en, mem_addr, din, valid_in, repeat_in, filter_adv, filter_sel} !== '0)
            $display("FAIL reset_outputs: got %b want all zero",
                     {busy, done, err, mem_rd_en, mem_addr, din, valid_in, repeat_in, filter_adv, filter_sel});
        else pass_cnt++;
        rst = 1'b0;
        tick(); tick();
        chk_cnt++;
        if ({busy, mem_rd_en, valid_in, done} !== 4'b0000) $display("FAIL idle_quiet: got %b want 0000", {busy, mem_rd_en, valid_in, done});
        else pass_cnt++;
    endtask

    task automatic test_single();
        int t0, vc0, dc0, ac0;
        bit ok;
        load_mem();
        ff_delay = 3;
        vc0 = valid_cnt; dc0 = done_cnt; ac0 = adv_cnt;
        t0 = cyc;
        start_layer();
        for (int k = 1; k <= 27; k++) begin
            chk_cnt++;
            if ({mem_rd_en, mem_addr, valid_in, busy} !== {(k <= 25), (k <= 25) ? AW'(k - 1) : AW'(0), (k >= 2 && k <= 26), 1'b1})
                $display("FAIL single_timing t+%0d: got rd=%b addr=%0d vld=%b busy=%b", k, mem_rd_en, mem_addr, valid_in, busy);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if (filter_adv !== 1'b0) $display("FAIL single_drain_adv: got %b want 0", filter_adv); else pass_cnt++;
        tick();
        chk_cnt++;
        if ({filter_adv, filter_sel, repeat_in} !== {1'b1, FW'(0), 1'b0} || valid_cnt - vc0 != 25)
            $display("FAIL single_adv: got adv=%b sel=%0d rep=%b vcnt=%0d want 1 0 0 25", filter_adv, filter_sel, repeat_in, valid_cnt - vc0);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({mem_rd_en, mem_addr, filter_sel, repeat_in, filter_adv} !== {1'b1, AW'(0), FW'(1), 1'b1, 1'b0})
            $display("FAIL single_pass1_start: got rd=%b addr=%0d sel=%0d rep=%b adv=%b", mem_rd_en, mem_addr, filter_sel, repeat_in, filter_adv);
        else pass_cnt++;
        wait_done(100, ok);
        chk_cnt++;
        if (!ok || cyc != t0 + 59) $display("FAIL single_done_time: got ok=%0d at t+%0d want t+59", ok, cyc - t0);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL single_after_done: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        tick(); tick();
        chk_cnt++;
        if (done_cnt - dc0 != 1 || adv_cnt - ac0 != 1 || valid_cnt - vc0 != 50 || sb_q.size() != 0 || err !== 1'b0)
            $display("FAIL single_totals: got done=%0d adv=%0d vld=%0d q=%0d err=%b want 1 1 50 0 0",
                     done_cnt - dc0, adv_cnt - ac0, valid_cnt - vc0, sb_q.size(), err);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int vc0, dc0, vp0;
        bit ok, got;
        load_mem();
        vc0 = valid_cnt; dc0 = done_cnt;
        stall_en = 1;
        start_layer();
        got = 0; vp0 = 0;
        for (int i = 0; i < 300; i++) begin
            if (filter_adv === 1'b1) begin got = 1; vp0 = valid_cnt - vc0; break; end
            tick();
        end
        chk_cnt++;
        if (!got || vp0 != 25) $display("FAIL stall_pass0: got adv_seen=%0d valid=%0d want 1 25", got, vp0);
        else pass_cnt++;
        wait_done(400, ok);
        stall_en = 0;
        tick(); tick();
        chk_cnt++;
        if (!ok || done_cnt - dc0 != 1 || valid_cnt - vc0 != 50 || sb_q.size() != 0)
            $display("FAIL stall_totals: got ok=%0d done=%0d valid=%0d q=%0d want 1 1 50 0", ok, done_cnt - dc0, valid_cnt - vc0, sb_q.size());
        else pass_cnt++;
    endtask

    task automatic test_err();
        int dc0;
        bit ok, got;
        load_mem();
        dc0 = done_cnt;
        start_layer();
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL err_initial: got %b want 0", err); else pass_cnt++;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (mem_rd_en === 1'b1 && mem_addr === AW'(10)) begin got = 1; break; end
            tick();
        end
        ff_force = 1'b1;
        tick();
        ff_force = 1'b0;
        chk_cnt++;
        if (!got || err !== 1'b1) $display("FAIL err_set: got found=%0d err=%b want 1 1", got, err); else pass_cnt++;
        wait_done(200, ok);
        chk_cnt++;
        if (!ok || err !== 1'b1) $display("FAIL err_sticky_done: got ok=%0d err=%b want 1 1", ok, err); else pass_cnt++;
        tick(); tick();
        chk_cnt++;
        if (err !== 1'b1 || done_cnt - dc0 != 1) $display("FAIL err_sticky_idle: got err=%b done=%0d want 1 1", err, done_cnt - dc0);
        else pass_cnt++;
        start_layer();
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL err_clear_on_start: got %b want 0", err); else pass_cnt++;
        wait_done(200, ok);
        tick();
        chk_cnt++;
        if (!ok || err !== 1'b0) $display("FAIL err_clean_layer: got ok=%0d err=%b want 1 0", ok, err); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int dc0, vc0;
        bit ok, got;
        load_mem();
        dc0 = done_cnt;
        start_layer();
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (filter_sel === FW'(1) && mem_rd_en === 1'b1 && mem_addr === AW'(8)) begin got = 1; break; end
            tick();
        end
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (!got || {busy, done, err, mem_rd_en, mem_addr, din, valid_in, repeat_in, filter_adv, filter_sel} !== '0)
            $display("FAIL rst_mid_outputs: got found=%0d outs=%b want all zero", got,
                     {busy, done, err, mem_rd_en, mem_addr, din, valid_in, repeat_in, filter_adv, filter_sel});
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        chk_cnt++;
        if (done_cnt != dc0 || busy !== 1'b0) $display("FAIL rst_mid_no_done: got done=%0d busy=%b want 0 0", done_cnt - dc0, busy);
        else pass_cnt++;
        load_mem();
        vc0 = valid_cnt;
        start_layer();
        wait_done(200, ok);
        tick(); tick();
        chk_cnt++;
        if (!ok || done_cnt - dc0 != 1 || valid_cnt - vc0 != 50 || sb_q.size() != 0 || err !== 1'b0)
            $display("FAIL rst_mid_rerun: got ok=%0d done=%0d valid=%0d q=%0d err=%b want 1 1 50 0 0",
                     ok, done_cnt - dc0, valid_cnt - vc0, sb_q.size(), err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t0, dc0;
        bit ok, busy_bad;
        load_mem();
        dc0 = done_cnt;
        t0 = cyc;
        start = 1'b1;
        tick();
        busy_bad = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin ok = 1; break; end
            if (busy !== 1'b1) busy_bad = 1;
            tick();
        end
        chk_cnt++;
        if (!ok || busy_bad || cyc != t0 + 59) $display("FAIL hold_single_layer: got ok=%0d busy_bad=%0d done at t+%0d want t+59", ok, busy_bad, cyc - t0);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL hold_idle_gap: got busy=%b want 0", busy); else pass_cnt++;
        tick();
        start = 1'b0;
        chk_cnt++;
        if ({mem_rd_en, mem_addr, busy, filter_sel} !== {1'b1, AW'(0), 1'b1, FW'(0)})
            $display("FAIL hold_second_start: got rd=%b addr=%0d busy=%b sel=%0d want 1 0 1 0", mem_rd_en, mem_addr, busy, filter_sel);
        else pass_cnt++;
        wait_done(200, ok);
        tick(); tick();
        chk_cnt++;
        if (!ok || done_cnt - dc0 != 2) $display("FAIL hold_two_layers: got ok=%0d done=%0d want 1 2", ok, done_cnt - dc0);
        else pass_cnt++;
    endtask

    task automatic test_finish_same_cycle();
        int t0;
        bit ok;
        load_mem();
        ff_delay = 0;
        t0 = cyc;
        start_layer();
        while (cyc < t0 + 26) tick();
        chk_cnt++;
        if ({filter_adv, valid_in, mem_rd_en} !== 3'b010) $display("FAIL same_drain: got adv=%b vld=%b rd=%b want 0 1 0", filter_adv, valid_in, mem_rd_en);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({filter_adv, mem_rd_en} !== 2'b10) $display("FAIL same_next: got adv=%b rd=%b want 1 0", filter_adv, mem_rd_en);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({mem_rd_en, mem_addr, repeat_in, filter_sel} !== {1'b1, AW'(0), 1'b1, FW'(1)})
            $display("FAIL same_pass1: got rd=%b addr=%0d rep=%b sel=%0d want 1 0 1 1", mem_rd_en, mem_addr, repeat_in, filter_sel);
        else pass_cnt++;
        wait_done(100, ok);
        chk_cnt++;
        if (!ok || cyc != t0 + 55) $display("FAIL same_done_time: got ok=%0d at t+%0d want t+55", ok, cyc - t0);
        else pass_cnt++;
        ff_delay = 3;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_err();
        test_rst_mid();
        test_back_to_back();
        test_finish_same_cycle();
        chk_cnt++;
        if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d outstanding want 0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
